scan_decoder: RTL and testbench

- Registered, parametrised N-to-2^N one-hot decoder; successor to the team's combinational 3-to-8 decoder.
- Direct mode: decodes a select value accepted over a valid/ready handshake.
- Scan mode: free-runs a walking one-hot across all outputs with a programmable dwell per position.
- Sits between control logic and row/digit-select lines (LED matrix, 7-seg digit mux, keypad column drive).

---
 rtl/scan_decoder.sv | 87 ++++++++
 tb/tb_scan_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N one-hot decoder with direct-select and auto-scan modes
module scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL   = 4,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    sel,
    output logic [2**SEL_W-1:0] y,
    output logic [SEL_W-1:0]    idx,
    output logic                out_valid,
    output logic                wrap
);

    localparam int N  = 2**SEL_W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SEL_W-1:0] idx_next;

    assign in_ready = en & ~mode;
    assign idx_next = idx + 1'b1;

    // active = 0 yields the blank pattern at the configured polarity
    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] s, input logic active);
        logic [N-1:0] d;
        d = '0;
        if (active) d[s] = 1'b1;
        return ACT_LOW ? ~d : d;
    endfunction

    // the (en, mode) pair alone picks the next state; actions depend on where we came from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OFF;
            y         <= decode('0, 1'b0);
            idx       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state     <= OFF;
                y         <= decode('0, 1'b0);
                out_valid <= 1'b0;
                cnt       <= '0;
            end else if (mode) begin
                state     <= SCAN;
                out_valid <= 1'b1;
                if (state != SCAN) begin
                    idx <= '0;
                    y   <= decode('0, 1'b1);
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt  <= '0;
                    idx  <= idx_next;
                    y    <= decode(idx_next, 1'b1);
                    wrap <= &idx;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                state <= DIRECT;
                if (in_valid) begin
                    idx       <= sel;
                    y         <= decode(sel, 1'b1);
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - randomized self-checking bench for scan_decoder (two configurations)
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n, en, mode, in_valid;
    logic [2:0] sel;
    logic [1:0] sel_b;

    wire [7:0] ya;
    wire [2:0] idxa;
    wire       va, wa, ra;
    wire [3:0] yb;
    wire [1:0] idxb;
    wire       vb, wb, rb;

    assign sel_b = sel[1:0];

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL(4), .ACT_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(ra), .sel(sel), .y(ya), .idx(idxa), .out_valid(va), .wrap(wa)
    );

    scan_decoder #(.SEL_W(2), .DWELL(1), .ACT_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rb), .sel(sel_b), .y(yb), .idx(idxb), .out_valid(vb), .wrap(wb)
    );

    // reference: scan position derived from cycles elapsed since scan entry
    int m_k;
    bit m_scan, m_valid, m_wa, m_wb;
    int m_ia, m_ib;

    always @(posedge clk or negedge rst_n) begin : model
        int nk;
        if (!rst_n) begin
            m_scan <= 0; m_k <= 0; m_valid <= 0; m_ia <= 0; m_ib <= 0; m_wa <= 0; m_wb <= 0;
        end else if (!en) begin
            m_scan <= 0; m_valid <= 0; m_wa <= 0; m_wb <= 0;
        end else if (mode) begin
            nk = m_scan ? m_k + 1 : 0;
            m_k     <= nk;
            m_scan  <= 1;
            m_valid <= 1;
            m_ia    <= (nk / 4) % 8;
            m_ib    <= nk % 4;
            m_wa    <= (nk > 0) && (nk % 32 == 0);
            m_wb    <= (nk > 0) && (nk % 4 == 0);
        end else begin
            m_scan <= 0; m_wa <= 0; m_wb <= 0;
            if (in_valid) begin
                m_ia    <= int'(sel);
                m_ib    <= int'(sel) % 4;
                m_valid <= 1;
            end
        end
    end

    wire [7:0]  eya  = m_valid ? (8'd1 << m_ia) : 8'd0;
    wire [3:0]  eyb  = ~(m_valid ? (4'd1 << m_ib) : 4'd0);
    wire        erdy = en & ~mode;
    wire [22:0] expv = {eya, 3'(m_ia), m_valid, m_wa, erdy, eyb, 2'(m_ib), m_valid, m_wb, erdy};
    wire [22:0] obs  = {ya, idxa, va, wa, ra, yb, idxb, vb, wb, rb};

    int checks = 0;
    int errors = 0;

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ya, idxa, va, wa, yb, vb, wb} !== {8'h00, 3'd0, 1'b0, 1'b0, 4'hf, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: ya=%h idxa=%0d va=%b wa=%b yb=%h vb=%b wb=%b want 00/0/0/0/f/0/0",
                     ya, idxa, va, wa, yb, vb, wb);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== expv) begin
            errors++; $display("FAIL reset_idle: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_direct();
        en = 1'b1; mode = 1'b0; in_valid = 1'b1; sel = 3'd5;
        @(negedge clk);
        checks++;
        if ({ya, idxa, va} !== {8'b0010_0000, 3'd5, 1'b1}) begin
            errors++; $display("FAIL direct_sel5: y=%b idx=%0d v=%b want 00100000/5/1", ya, idxa, va);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sel = 3'($urandom);
            @(negedge clk);
            checks++;
            if (ya !== 8'b0010_0000 || obs !== expv) begin
                errors++; $display("FAIL direct_hold[%0d]: y=%b obs=%h want y=00100000 exp=%h", i, ya, obs, expv);
            end
        end
    endtask

    task automatic test_sweep();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            @(negedge clk);
            checks++;
            if (ya !== (8'd1 << i) || yb !== ~(4'd1 << (i % 4)) || obs !== expv) begin
                errors++; $display("FAIL sweep[%0d]: ya=%b yb=%b obs=%h exp=%h", i, ya, yb, obs, expv);
            end
        end
        sel = 3'd2;
        @(negedge clk);
        checks++;
        if (yb !== 4'b1011) begin
            errors++; $display("FAIL act_low_sel2: yb=%b want 1011", yb);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_scan();
        int wraps_a = 0, wraps_b = 0;
        mode = 1'b1;
        for (int k = 0; k < 70; k++) begin
            in_valid = 1'($urandom); sel = 3'($urandom);
            @(negedge clk);
            wraps_a += int'(wa); wraps_b += int'(wb);
            checks++;
            if (idxa !== 3'((k / 4) % 8) || idxb !== 2'(k % 4) || ra !== 1'b0 || obs !== expv) begin
                errors++;
                $display("FAIL scan[%0d]: idxa=%0d idxb=%0d ra=%b obs=%h want idxa=%0d idxb=%0d exp=%h",
                         k, idxa, idxb, ra, obs, (k / 4) % 8, k % 4, expv);
            end
        end
        checks++;
        if (wraps_a != 2 || wraps_b != 17) begin
            errors++; $display("FAIL scan_wrap_count: a=%0d b=%0d want 2 17", wraps_a, wraps_b);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_midop();
        logic [7:0] held;
        int guard = 0;
        while (idxa !== 3'd3 && guard < 64) begin
            @(negedge clk); guard++;
        end
        checks++;
        if (guard >= 64) begin
            errors++; $display("FAIL wait_idx3: idxa=%0d want 3 within 64 cycles", idxa);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({ya, va, idxa} !== {8'h00, 1'b0, 3'd3} || obs !== expv) begin
            errors++; $display("FAIL drop_en: y=%h v=%b idx=%0d want 00/0/3", ya, va, idxa);
        end
        en = 1'b1; mode = 1'b1;
        repeat (6) @(negedge clk);
        held = ya;
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 3'($urandom);
            @(negedge clk);
            checks++;
            if (ya !== held || va !== 1'b1 || obs !== expv) begin
                errors++; $display("FAIL scan_to_direct_hold[%0d]: y=%b want %b obs=%h exp=%h", i, ya, held, obs, expv);
            end
        end
        in_valid = 1'b1; sel = 3'd6;
        @(negedge clk);
        checks++;
        if (ya !== 8'b0100_0000 || idxa !== 3'd6) begin
            errors++; $display("FAIL direct_sel6: y=%b idx=%0d want 01000000/6", ya, idxa);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reentry();
        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (idxa !== 3'(k / 4) || wa !== 1'b0 || va !== 1'b1 || obs !== expv) begin
                errors++; $display("FAIL reentry[%0d]: idx=%0d wrap=%b want idx=%0d wrap=0", k, idxa, wa, k / 4);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (wb !== 1'b1 && guard < 16) begin
            @(negedge clk); guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (guard >= 16 || {ya, va, wa, yb, vb, wb} !== {8'h00, 1'b0, 1'b0, 4'hf, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: guard=%0d ya=%h va=%b wa=%b yb=%h vb=%b wb=%b want 00/0/0/f/0/0",
                     guard, ya, va, wa, yb, vb, wb);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (idxa !== 3'd0 || va !== 1'b1 || wb !== 1'b0 || obs !== expv) begin
            errors++; $display("FAIL post_reset_scan: idx=%0d v=%b obs=%h exp=%h", idxa, va, obs, expv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_valid = 1'($urandom);
            sel      = 3'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL random[%0d]: got %h want %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_sweep();
        test_scan();
        test_midop();
        test_reentry();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
